// File: rtl/match_position_encoder_pkg.sv
// match_position_encoder_pkg: shared state type and default geometry for the match position encoder.
package match_position_encoder_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int WORD_W_DEF = 16;
  localparam int POS_W = $clog2(WORD_W_DEF);
endpackage

// File: rtl/match_position_encoder_msb_find.sv
// msb_find: highest set bit index, any-bit and exactly-one-bit detection of a vector.
module msb_find #(
  parameter int W = 16
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] idx,
  output logic                 any,
  output logic                 onehot
);
  localparam int IW = $clog2(W);
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) idx = vec[i] ? IW'(i) : idx;
  end
  assign any = |vec;
  assign onehot = any && ~|(vec & (vec - W'(1)));
endmodule

// File: rtl/match_position_encoder.sv
// match_position_encoder: serialises the set bits of a detect-flag word into positions, MSB first.
module match_position_encoder
  import match_position_encoder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_W-1:0]         word_in,
  input  logic                      word_valid,
  output logic                      word_ready,
  output logic [$clog2(WORD_W)-1:0] pos_out,
  output logic                      pos_valid,
  input  logic                      pos_ready,
  output logic                      pos_last,
  output logic                      empty_word,
  output logic [$clog2(WORD_W):0]   match_count,
  output logic [CNT_W-1:0]          total_count,
  input  logic                      clr_total
);
  localparam int PW = $clog2(WORD_W);
  state_t            r_state;
  logic [WORD_W-1:0] r_shadow;
  logic [PW:0]       r_match_count;
  logic [PW:0]       w_pop;
  logic [CNT_W-1:0]  r_total;
  logic              r_empty;
  logic [PW-1:0]     w_idx;
  logic              w_any;
  logic              w_onehot;
  logic              w_accept;
  logic              w_take;
  msb_find #(.W(WORD_W)) u_msb (
    .vec    (r_shadow),
    .idx    (w_idx),
    .any    (w_any),
    .onehot (w_onehot)
  );
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WORD_W; i++) w_pop = w_pop + (PW + 1)'(word_in[i]);
  end
  assign word_ready  = (r_state == IDLE);
  assign pos_valid   = (r_state == SCAN) && w_any;
  assign pos_out     = w_idx;
  assign pos_last    = w_onehot;
  assign empty_word  = r_empty;
  assign match_count = r_match_count;
  assign total_count = r_total;
  assign w_accept    = word_valid && word_ready;
  assign w_take      = pos_valid && pos_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_match_count <= '0;
      r_total       <= '0;
      r_empty       <= 1'b0;
    end else begin
      r_empty <= w_accept && ~|word_in;
      if (clr_total) r_total <= '0;
      else if (w_take && ~&r_total) r_total <= r_total + CNT_W'(1);
      if (w_accept) begin
        r_shadow      <= word_in;
        r_match_count <= w_pop;
        r_state       <= |word_in ? SCAN : IDLE;
      end else if (w_take) begin
        // a held position leaves the shadow untouched, so pos_out stays stable
        r_shadow <= r_shadow & ~(WORD_W'(1) << w_idx);
        r_state  <= w_onehot ? IDLE : SCAN;
      end
    end
  end
endmodule

// File: tb/tb_match_position_encoder.sv
// tb_match_position_encoder: randomized scoreboard bench with a position-queue reference model.
module tb_match_position_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [3:0]  pos_out;
  logic        pos_valid;
  logic        pos_ready = 1'b0;
  logic        pos_last;
  logic        empty_word;
  logic [4:0]  match_count;
  logic [3:0]  total_count;
  logic        clr_total = 1'b0;
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  bit rand_rdy = 0;
  int exp_q[$];
  int exp_total = 0;
  int exp_mc = 0;
  bit exp_empty = 0;

  always #5 clk = ~clk;

  match_position_encoder #(.WORD_W(16), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pos_out     (pos_out),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_last    (pos_last),
    .empty_word  (empty_word),
    .match_count (match_count),
    .total_count (total_count),
    .clr_total   (clr_total)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compare what the DUT shows this cycle, then advance the model by the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("word_ready", int'(word_ready), int'(exp_q.size() == 0));
      chk("pos_valid", int'(pos_valid), int'(exp_q.size() != 0));
      if (pos_valid && exp_q.size() != 0) begin
        chk("pos_out", int'(pos_out), exp_q[0]);
        chk("pos_last", int'(pos_last), int'(exp_q.size() == 1));
      end
      chk("empty_word", int'(empty_word), int'(exp_empty));
      chk("match_count", int'(match_count), exp_mc);
      chk("total_count", int'(total_count), exp_total);
    end
    if (reset) begin
      exp_q.delete();
      exp_total = 0;
      exp_mc = 0;
      exp_empty = 0;
      armed = 1;
    end else if (armed) begin
      exp_empty = 0;
      if (pos_valid && pos_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_total < 15) exp_total++;
      end
      if (clr_total) exp_total = 0;
      if (word_valid && word_ready) begin
        for (int k = 15; k >= 0; k--) if (word_in[k]) exp_q.push_back(k);
        exp_mc = $countones(word_in);
        exp_empty = (word_in == 16'h0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) pos_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    bit acc;
    word_valid = 1'b1;
    word_in = w;
    n = 0;
    do begin
      acc = word_ready && !reset;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word %h: got no word_ready expected acceptance", w);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    pos_ready = 1'b1;
    send(16'h8001);
    word_valid = 1'b0;
    repeat (3) tick();
    send(16'h0000);
    word_valid = 1'b0;
    repeat (3) tick();
    pos_ready = 1'b0;
    send(16'h0124);
    word_in = 16'h00F0;
    repeat (3) tick();
    word_valid = 1'b0;
    pos_ready = 1'b1;
    repeat (4) tick();
    send(16'hFFFF);
    word_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 9; i++) send(16'h0003);
    word_valid = 1'b0;
    repeat (3) tick();
    send(16'h0003);
    word_valid = 1'b0;
    clr_total = 1'b1;
    tick();
    clr_total = 1'b0;
    repeat (3) tick();
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: send(16'h0000);
        1: send(16'($urandom));
        default: send(16'($urandom & $urandom & $urandom));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        word_valid = 1'b0;
        tick();
      end
      clr_total = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    word_valid = 1'b0;
    clr_total = 1'b0;
    rand_rdy = 0;
    pos_ready = 1'b1;
    n = 0;
    while (!word_ready && n < 100) begin
      tick();
      n++;
    end
    if (!word_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got word_ready 0 expected 1");
    end
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
